// File: rtl/subbytes_bank_scheduler.sv
// Shares one N_LANES-byte S-box bank between the round datapath and the key
// schedule: acceptance, arbitration, in-flight tagging and reassembly.
module subbytes_bank_scheduler #(
   parameter int NB_BYTE      = 8,
   parameter int N_BYTES      = 16,
   parameter int N_LANES      = 4,
   parameter int SBOX_LATENCY = 1
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_state_valid,
   input  logic [N_BYTES*NB_BYTE-1:0] i_state,
   output logic                       o_state_ready,
   output logic [N_BYTES*NB_BYTE-1:0] o_state,
   output logic                       o_state_valid,
   input  logic                       i_key_valid,
   input  logic [N_LANES*NB_BYTE-1:0] i_key_word,
   output logic                       o_key_ready,
   output logic [N_LANES*NB_BYTE-1:0] o_key_word,
   output logic                       o_key_valid,
   output logic [N_LANES*NB_BYTE-1:0] o_sbox_bytes,
   output logic                       o_sbox_valid,
   input  logic [N_LANES*NB_BYTE-1:0] i_sbox_bytes
);

   localparam int N_SLICES = N_BYTES / N_LANES;
   localparam int NB_WORD  = N_LANES * NB_BYTE;
   localparam int CW       = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_SLICES - 1);

   if ((NB_BYTE != 8) || (N_LANES < 1) || (N_BYTES < N_LANES) ||
       ((N_BYTES % N_LANES) != 0) ||
       (SBOX_LATENCY < 0) || (SBOX_LATENCY > 1)) begin : g_bad_cfg
      $error("subbytes_bank_scheduler: unsupported parameter set");
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } fsm_t;

   typedef struct packed {
      logic          vld;
      logic          key;
      logic [CW-1:0] idx;
   } tag_t;

   fsm_t                             fsm_q;
   fsm_t                             fsm_d;
   logic [CW-1:0]                    cnt_q;
   logic [N_SLICES-1:0][NB_WORD-1:0] buf_q;
   logic [N_SLICES-1:0][NB_WORD-1:0] res_q;
   logic [NB_WORD-1:0]               key_q;
   logic [NB_WORD-1:0]               key_res_q;
   logic                             key_pending;
   logic                             last_key;
   logic                             state_vld_q;
   logic                             key_vld_q;

   logic state_acc;
   logic key_acc;
   logic gnt_d;
   logic gnt_k;
   logic done;
   tag_t tag_in;
   tag_t tag_cap;

   assign o_state_ready = !i_reset && (fsm_q == IDLE);
   assign o_key_ready   = !i_reset && !key_pending;
   assign state_acc     = i_state_valid && o_state_ready;
   assign key_acc       = i_key_valid && o_key_ready;

   // Key wins a contended slot unless it also won the previous one.
   assign gnt_k = !i_reset && key_pending &&
                  ((fsm_q != ISSUE) || !last_key);
   assign gnt_d = !i_reset && (fsm_q == ISSUE) && !gnt_k;

   always_comb begin
      o_sbox_bytes = '0;
      if (gnt_k) begin
         o_sbox_bytes = key_q;
      end else if (gnt_d) begin
         o_sbox_bytes = buf_q[cnt_q];
      end
   end

   assign o_sbox_valid = gnt_k || gnt_d;

   always_comb begin
      tag_in     = '0;
      tag_in.vld = gnt_k || gnt_d;
      tag_in.key = gnt_k;
      tag_in.idx = cnt_q;
   end

   if (SBOX_LATENCY == 0) begin : g_lat0
      assign tag_cap = tag_in;
   end else begin : g_lat1
      tag_t tag_q;

      always_ff @(posedge i_clock) begin
         if (i_reset) begin
            tag_q <= '0;
         end else begin
            tag_q <= tag_in;
         end
      end

      assign tag_cap = tag_q;
   end

   assign done = tag_cap.vld && !tag_cap.key && (tag_cap.idx == LAST);

   always_comb begin
      fsm_d = fsm_q;
      unique case (fsm_q)
         IDLE: begin
            if (state_acc) begin
               fsm_d = ISSUE;
            end
         end
         ISSUE: begin
            if (done) begin
               fsm_d = IDLE;
            end else if (gnt_d && (cnt_q == LAST)) begin
               fsm_d = WAIT;
            end
         end
         WAIT: begin
            if (done) begin
               fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         fsm_q       <= IDLE;
         cnt_q       <= '0;
         buf_q       <= '0;
         res_q       <= '0;
         state_vld_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_vld_q <= done;
         if (state_acc) begin
            buf_q <= i_state;
            cnt_q <= '0;
         end else if (gnt_d && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (tag_cap.vld && !tag_cap.key) begin
            res_q[tag_cap.idx] <= i_sbox_bytes;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         key_q       <= '0;
         key_pending <= 1'b0;
         last_key    <= 1'b0;
         key_res_q   <= '0;
         key_vld_q   <= 1'b0;
      end else begin
         last_key  <= gnt_k;
         key_vld_q <= tag_cap.vld && tag_cap.key;
         if (key_acc) begin
            key_q       <= i_key_word;
            key_pending <= 1'b1;
         end else if (gnt_k) begin
            key_pending <= 1'b0;
         end
         if (tag_cap.vld && tag_cap.key) begin
            key_res_q <= i_sbox_bytes;
         end
      end
   end

   assign o_state       = res_q;
   assign o_state_valid = state_vld_q;
   assign o_key_word    = key_res_q;
   assign o_key_valid   = key_vld_q;

endmodule

// File: doc/subbytes_bank_scheduler.md
# subbytes_bank_scheduler

Time-multiplexes one narrow S-box bank, an N_LANES-byte `subbytes_block` instance, between two requesters. The first is the round datapath: a full N_BYTES state, folded into N_SLICES slices. The second is the key schedule: one N_LANES-byte SubWord per request. The block sits between the AES round controller/key expander and the bank. It owns request acceptance, slot arbitration, in-flight tagging and result reassembly. The bank itself lives outside this block.

## Interface
- NB_BYTE, 8, bits per byte; any other value is a bad configuration.
- N_BYTES, 16, bytes per datapath state.
- N_LANES, 4, S-box lanes in the bank; also the key word width in bytes. N_BYTES % N_LANES must be 0.
- SBOX_LATENCY, 1, bank latency in cycles. Must be 0 or 1, matching the bank's CREATE_OUTPUT_REG.
- (derived) N_SLICES = N_BYTES / N_LANES; NB_WORD = N_LANES*NB_BYTE.

- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  synchronous, active-high.
- i_state_valid  in  1  state request.
- i_state  in  N_BYTES*NB_BYTE  state; byte k at [k*NB_BYTE +: NB_BYTE].
- o_state_ready  out  1  state request accepted when valid&ready at a rising edge.
- o_state  out  N_BYTES*NB_BYTE  substituted state.
- o_state_valid  out  1  one-cycle pulse; o_state is valid in that cycle.
- i_key_valid  in  1  key word request.
- i_key_word  in  NB_WORD  word to substitute.
- o_key_ready  out  1  key request accepted when valid&ready at a rising edge.
- o_key_word  out  NB_WORD  substituted word.
- o_key_valid  out  1  one-cycle pulse.
- o_sbox_bytes  out  NB_WORD  bank input.
- o_sbox_valid  out  1  bank input valid.
- i_sbox_bytes  in  NB_WORD  bank output, SBOX_LATENCY cycles after issue.

## Operation
- Data FSM states: IDLE, ISSUE, WAIT.
  - IDLE: o_state_ready=1. On acceptance, register i_state, set slice counter to 0, go to ISSUE.
  - ISSUE: request a bank slot each cycle. On each grant, issue slice bytes [cnt*N_LANES +: N_LANES] and increment the counter. After slice N_SLICES-1 is granted, go to WAIT.
  - WAIT: when the last slice result is captured, pulse o_state_valid and go to IDLE.
- Key path:
  - o_key_ready=1 while no key word is held.
  - On acceptance, register the word and set key_pending.
  - When granted, issue the word, clear key_pending, and allow a new key to be accepted the next cycle.
- Arbitration, one issue per cycle:
  - If only one requester is pending, it is granted.
  - If both are pending, key wins unless the previous cycle's grant went to key; then data wins (1-bit last_grant flag).
  - Data therefore progresses at least every other cycle.
- Tag pipeline of depth SBOX_LATENCY carries {valid, owner, slice index}. With SBOX_LATENCY=0 the tag is combinational from the grant.
- Capture:
  - Data results are written into o_state at [idx*N_LANES*NB_BYTE +: NB_WORD].
  - Key results are registered into o_key_word, and o_key_valid pulses the next cycle.
- o_sbox_bytes = granted word, or 0 when there is no grant; o_sbox_valid = grant.
- o_state and o_key_word hold their last value until overwritten. There is no output backpressure.
- A new state may be accepted in the same cycle o_state_valid pulses.
- Bad configuration halts elaboration via a generate-time error.

## Timing
- Cycle 0 is the acceptance edge.
- Uncontended data: slice k is issued in cycle k+1; o_state_valid fires in cycle N_SLICES+SBOX_LATENCY+1 (default 6).
- Uncontended key: issued in cycle 1; o_key_valid fires in cycle SBOX_LATENCY+2 (default 3).
- Each contended cycle lost to key delays data completion by 1. A data state completes within 2*N_SLICES+SBOX_LATENCY+1 cycles under continuous key traffic.
- Reset behaviour:
  - While i_reset is high, every output is 0, including both readies.
  - Readies go to 1 in the first cycle after reset deasserts.
  - Reset mid-operation discards registered requests and in-flight tags; no valid pulses are emitted for them.
- Simultaneous state and key acceptance in cycle 0: key issues in cycle 1, data slice 0 in cycle 2. Data completes one cycle late.

## Test plan
- Single state, defaults: i_state = 128'hffeeddccbbaa99887766554433221100 -> o_state_valid in cycle 6 with o_state = 128'h16_28_c1_4b_ea_ac_ee_c4_f5_33_fc_1b_c3_93_82_63 (byte 0 = 8'h63). o_sbox_valid high for cycles 1-4 only.
- Single key: i_key_word = 32'h093c4fcf -> o_key_valid in cycle 3 with o_key_word = 32'h01eb848a.
- Simultaneous state and key at cycle 0 -> grant order key, d0, d1, d2, d3. o_key_valid in cycle 3; o_state_valid in cycle 7 with the correct state.
- Back-to-back key words, one per accepted cycle, during a state -> grants alternate key/data. o_state_valid no later than cycle 10, and all key results are correct and in order.
- Repeat the state test with SBOX_LATENCY=0 -> o_state_valid in cycle 5.
- Assert i_reset in cycle 3 of an active state -> no o_state_valid pulse. Readies are 0 during reset and 1 afterwards. A fresh state then completes 6 cycles after acceptance.
